out_uart_tx: RTL and testbench
==============================

Name: out_uart_tx

Overview:
- Downstream consumer of the CPU's OUT instruction.
- Captures each byte the CPU presents on its 8-bit output bus with the one-cycle Lr strobe into a small FIFO, then serialises the bytes as 8N1 UART frames on a single tx pin.
- The CPU never stalls on OUT, so the block absorbs bursts and flags any byte it has to drop.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit. Integer, 2 or more.
- FIFO_DEPTH, 8: byte entries. Power of two, 2 to 256.
- PTR_W, log2(FIFO_DEPTH): pointer width. Derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- out_data  in  8  byte from the CPU LEDS output
- out_strobe  in  1  CPU Lr; high for one cycle when out_data is valid
- tx  out  1  UART serial line; idles high
- busy  out  1  high while a frame is in flight or the FIFO is non-empty
- overflow  out  1  sticky; set when a strobed byte was dropped
- fifo_count  out  PTR_W+1  current FIFO occupancy, 0 to FIFO_DEPTH

Behaviour:
- Reset (async, any time, including mid-frame):
  - tx=1, busy=0, overflow=0, fifo_count=0.
  - Pointers are cleared and the FSM goes to IDLE.
  - A partial frame is abandoned; tx returns high without waiting for a clock edge.
- Write side:
  - On posedge with out_strobe=1, out_data is written at the write pointer and the pointer increments modulo FIFO_DEPTH.
  - Accepted only if fifo_count<FIFO_DEPTH, or a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set; it stays set until rst.
  - Consecutive strobes on back-to-back cycles are each accepted.
- Occupancy: fifo_count = pushes minus pops. A simultaneous push and pop leaves it unchanged, including at full and at empty+1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count>0 on a posedge, pop the head into an 8-bit shift register, clear the bit counter and baud counter, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After 8 bits go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and resets on every state change.
- Latency:
  - Strobe captured at edge N. The pop and the start bit begin at edge N+1 if the FSM was IDLE with an empty FIFO. tx falls at N+1.
  - Frame length is 10*CLKS_PER_BIT cycles.
  - Between consecutive frames, IDLE lasts exactly one cycle: frame pitch is 10*CLKS_PER_BIT+1 cycles.
- tx is driven from a register; no combinational path from inputs to tx.
- busy = (state!=IDLE) or (fifo_count!=0).
- Pointer wrap: pointers are PTR_W bits and wrap naturally. Full/empty are decided by fifo_count, not by pointer comparison.
- A strobe arriving in the same cycle as the IDLE pop with fifo_count==1 is accepted; count stays 1.
- An out_data value with X bits is stored as-is; no checking.

Optional Feature:
- Macro: OUT_UART_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT and pitch 11*CLKS_PER_BIT+1.
- Undefined: no PARITY state, no parity logic; pure 8N1 as above.

Test Plan:
- Reset, then one strobe with out_data=8'hA5, CLKS_PER_BIT=16 -> tx low from the next edge for 16 cycles, then bits 1,0,1,0,0,1,0,1 (LSB first) at 16 cycles each, then high 16 cycles; busy falls after 161 cycles; overflow=0.
- Strobes on 3 consecutive cycles with 8'h01, 8'h02, 8'h03 -> fifo_count peaks at 2; three frames decode in order 01, 02, 03; frame starts are 161 cycles apart.
- With FIFO_DEPTH=8, send 10 strobes back-to-back while idle -> first byte popped immediately, next 8 stored, 10th dropped, overflow=1; 9 frames transmitted; overflow stays 1 after busy=0.
- Keep FIFO full (8) and strobe on the exact cycle of a pop -> byte accepted, fifo_count stays 8, overflow stays 0.
- Assert rst mid-DATA of byte 8'hFF with 3 bytes queued -> tx=1 immediately and asynchronously; fifo_count=0, busy=0; a new strobe of 8'h3C after release transmits correctly.
- OUT_UART_PARITY_EN defined: send 8'h07 -> parity bit 1; send 8'h03 -> parity bit 0; both frames are 176 cycles long with CLKS_PER_BIT=16.

Source files
------------

// File: rtl/out_uart_tx_if.sv
// Bus between the CPU OUT port and the UART transmitter: byte/strobe in, line and status out.
interface out_uart_tx_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       out_data;
    logic             out_strobe;
    logic             tx;
    logic             busy;
    logic             overflow;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output out_data, out_strobe,
        input  tx, busy, overflow, fifo_count
    );

    modport slave (
        input  out_data, out_strobe,
        output tx, busy, overflow, fifo_count
    );
endinterface

// File: rtl/out_uart_tx.sv
// Byte FIFO fed by the CPU OUT strobe, drained as 8N1 UART frames on a registered tx pin.
// Optional even-parity bit between data and stop when OUT_UART_PARITY_EN is defined.
module out_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic         clk,
    input  logic         rst,
    out_uart_tx_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
`ifdef OUT_UART_PARITY_EN
        , ST_PARITY
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic              push, pop, baud_done;
`ifdef OUT_UART_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    // Next-state, FIFO bookkeeping and the registered line value
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + BAUD_W'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        pop        = 1'b0;
`ifdef OUT_UART_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    bit_d   = '0;
                    state_d = ST_START;
`ifdef OUT_UART_PARITY_EN
                    parity_d = ^mem_q[rd_ptr_q];
`endif
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
`ifdef OUT_UART_PARITY_EN
            ST_PARITY: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        // A pop in the same cycle frees a slot, so a full FIFO still accepts
        push       = bus.out_strobe && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);
        overflow_d = overflow_q || (bus.out_strobe && !push);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        busy_d     = (state_d != ST_IDLE) || (count_d != '0);

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef OUT_UART_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
`ifdef OUT_UART_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
`ifdef OUT_UART_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Storage needs no reset; occupancy alone says what is valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.out_data;
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_out_uart_tx.sv
// Random and directed OUT strobes checked every cycle against a frame-timing model of the UART.
module tb_out_uart_tx;
    localparam int CPB   = 16;
    localparam int DEPTH = 8;
`ifdef OUT_UART_PARITY_EN
    localparam int FRAME = 11 * CPB;
    localparam bit PAR   = 1'b1;
`else
    localparam int FRAME = 10 * CPB;
    localparam bit PAR   = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    out_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: each accepted byte with its accept edge and the edge its frame starts
    int         acc_q[$];
    int         pop_q[$];
    logic [7:0] byte_q[$];
    int         last_pop;
    int         drop_first;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): observed %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic void model_reset();
        acc_q.delete();
        pop_q.delete();
        byte_q.delete();
        last_pop   = -1000000;
        drop_first = 32'h7fffffff;
    endfunction

    function automatic bit pop_at(input int e);
        foreach (pop_q[i]) if (pop_q[i] == e) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int occ_before(input int e);
        int n = 0;
        foreach (acc_q[i]) if (acc_q[i] < e) n++;
        foreach (pop_q[i]) if (pop_q[i] < e) n--;
        return n;
    endfunction

    function automatic int cnt_after(input int e);
        int n = 0;
        foreach (acc_q[i]) if (acc_q[i] <= e) n++;
        foreach (pop_q[i]) if (pop_q[i] <= e) n--;
        return n;
    endfunction

    function automatic bit in_frame(input int e);
        foreach (pop_q[i]) if (e >= pop_q[i] && e < pop_q[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit tx_exp(input int e);
        int o;
        foreach (pop_q[i]) begin
            if (e >= pop_q[i] && e < pop_q[i] + FRAME) begin
                o = (e - pop_q[i]) / CPB;
                if (o == 0) return 1'b0;
                if (o <= 8) return byte_q[i][o-1];
                if (PAR && o == 9) return ^byte_q[i];
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    task automatic check_cycle(input int e);
        bit b;
        b = (cnt_after(e) != 0) || in_frame(e);
        check_eq("tx",         32'(bus.tx),         32'(tx_exp(e)));
        check_eq("busy",       32'(bus.busy),       32'(b));
        check_eq("overflow",   32'(bus.overflow),   32'(drop_first <= e));
        check_eq("fifo_count", 32'(bus.fifo_count), 32'(cnt_after(e)));
    endtask

    // Called at a negedge: drive inputs for the coming edge, then check after it
    task automatic step(input bit stb, input logic [7:0] d);
        int e = cyc + 1;
        int p;
        bus.out_strobe = stb;
        bus.out_data   = d;
        if (stb) begin
            if (occ_before(e) < DEPTH || pop_at(e)) begin
                p = (e + 1 > last_pop + FRAME + 1) ? e + 1 : last_pop + FRAME + 1;
                acc_q.push_back(e);
                byte_q.push_back(d);
                pop_q.push_back(p);
                last_pop = p;
            end else if (drop_first > e) begin
                drop_first = e;
            end
        end
        @(negedge clk);
        check_cycle(cyc);
    endtask

    task automatic drain();
        int n = 0;
        while ((cnt_after(cyc) != 0 || in_frame(cyc)) && n < 20000) begin
            step(1'b0, 8'h00);
            n++;
        end
        if (n >= 20000) check_eq("drain_timeout", 32'd1, 32'd0);
        step(1'b0, 8'h00);
    endtask

    // Reset lands between edges; the line must go high without a clock
    task automatic async_reset();
        bus.out_strobe = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("rst_tx",         32'(bus.tx),         32'd1);
        check_eq("rst_busy",       32'(bus.busy),       32'd0);
        check_eq("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
        check_eq("rst_overflow",   32'(bus.overflow),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int n;
        int burst;
        bus.out_strobe = 1'b0;
        bus.out_data   = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("init_tx",         32'(bus.tx),         32'd1);
        check_eq("init_busy",       32'(bus.busy),       32'd0);
        check_eq("init_overflow",   32'(bus.overflow),   32'd0);
        check_eq("init_fifo_count", 32'(bus.fifo_count), 32'd0);
        rst = 1'b0;

        step(1'b1, 8'hA5);
        drain();

        step(1'b1, 8'h01);
        step(1'b1, 8'h02);
        step(1'b1, 8'h03);
        drain();

        // Ten back-to-back while idle: one popped at once, eight stored, last dropped
        async_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h10 + i));
        check_eq("burst_overflow", 32'(bus.overflow), 32'd1);
        drain();
        check_eq("burst_overflow_sticky", 32'(bus.overflow), 32'd1);

        // Full FIFO accepts a strobe on the exact pop edge
        async_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h40 + i));
        n = 0;
        while (!pop_at(cyc + 1) && n < 1000) begin
            step(1'b0, 8'h00);
            n++;
        end
        if (n >= 1000) check_eq("pop_wait_timeout", 32'd1, 32'd0);
        step(1'b1, 8'hC3);
        check_eq("full_pop_count",    32'(bus.fifo_count), 32'(DEPTH));
        check_eq("full_pop_overflow", 32'(bus.overflow),   32'd0);
        drain();

        // Abandon a frame mid-data with bytes queued
        async_reset();
        step(1'b1, 8'hFF);
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        step(1'b1, 8'h33);
        repeat (4 * CPB + 5) step(1'b0, 8'h00);
        async_reset();
        step(1'b1, 8'h3C);
        drain();

        // Reset while the line is low
        step(1'b1, 8'h00);
        repeat (4 * CPB) step(1'b0, 8'h00);
        async_reset();

        step(1'b1, 8'h07);
        drain();
        step(1'b1, 8'h03);
        drain();

        burst = 0;
        for (int i = 0; i < 6000; i++) begin
            if (burst == 0 && $urandom_range(0, 499) == 0) burst = int'($urandom_range(2, 12));
            if (burst > 0) begin
                step(1'b1, 8'($urandom));
                burst--;
            end else begin
                step($urandom_range(0, 59) == 0, 8'($urandom));
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
